// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (CPU and debug/loader) in front of a single-ported memory
// with fixed read latency; one transaction in flight, round-robin on ties.
module mem_port_arbiter #(
    parameter int unsigned AW     = 32,
    parameter int unsigned DW     = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_adr,
    input  logic [DW-1:0] cpu_wd,
    output logic [DW-1:0] cpu_rd,
    output logic          cpu_done,
    output logic          cpu_stall,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_adr,
    input  logic [DW-1:0] dbg_wd,
    output logic [DW-1:0] dbg_rd,
    output logic          dbg_done,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd,
    output logic          owner,
    output logic [1:0]    state
);

    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t        st;
    logic          last_grant;
    logic          mem_we_q;
    logic [CW-1:0] cnt;
    logic          pick_dbg;

    // Debug wins when alone, or on a tie when the CPU had the previous grant.
    assign pick_dbg  = dbg_req & (~cpu_req | ~last_grant);
    assign cpu_stall = cpu_req & ~cpu_done;
    assign state     = st;

    always_ff @(posedge clk) begin
        if (reset) begin
            st         <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_adr    <= '0;
            mem_wd     <= '0;
            cpu_rd     <= '0;
            dbg_rd     <= '0;
            cpu_done   <= 1'b0;
            dbg_done   <= 1'b0;
            cnt        <= '0;
        end else begin
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            cpu_done <= 1'b0;
            dbg_done <= 1'b0;
            case (st)
                IDLE: begin
                    if (cpu_req || dbg_req) begin
                        owner      <= pick_dbg;
                        last_grant <= pick_dbg;
                        mem_we_q   <= pick_dbg ? dbg_we  : cpu_we;
                        mem_we     <= pick_dbg ? dbg_we  : cpu_we;
                        mem_adr    <= pick_dbg ? dbg_adr : cpu_adr;
                        mem_wd     <= pick_dbg ? dbg_wd  : cpu_wd;
                        mem_en     <= 1'b1;
                        st         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_we_q) begin
                        cpu_done <= ~owner;
                        dbg_done <= owner;
                        st       <= RESP;
                    end else begin
                        cnt <= CW'(RD_LAT);
                        st  <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - CW'(1);
                    // Last wait cycle: read data is valid RD_LAT cycles after issue.
                    if (cnt == CW'(1)) begin
                        if (owner) begin
                            dbg_rd <= mem_rd;
                        end else begin
                            cpu_rd <= mem_rd;
                        end
                        cpu_done <= ~owner;
                        dbg_done <= owner;
                        st       <= RESP;
                    end
                end
                RESP: begin
                    st <= IDLE;
                end
                default: begin
                    st <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: instance a uses RD_LAT=2, instance b uses RD_LAT=3.
module tb_mem_port_arbiter;

    logic clk;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic        reset_a, cpu_req_a, cpu_we_a, dbg_req_a, dbg_we_a;
    logic [31:0] cpu_adr_a, cpu_wd_a, dbg_adr_a, dbg_wd_a, cpu_rd_a, dbg_rd_a;
    logic        cpu_done_a, cpu_stall_a, dbg_done_a, mem_en_a, mem_we_a, owner_a;
    logic [31:0] mem_adr_a, mem_wd_a, mem_rd_a, mem_drv_a;
    logic [1:0]  state_a;
    logic        use_model;

    logic        reset_b, cpu_req_b, cpu_we_b, dbg_req_b, dbg_we_b;
    logic [31:0] cpu_adr_b, cpu_wd_b, dbg_adr_b, dbg_wd_b, cpu_rd_b, dbg_rd_b;
    logic        cpu_done_b, cpu_stall_b, dbg_done_b, mem_en_b, mem_we_b, owner_b;
    logic [31:0] mem_adr_b, mem_wd_b, mem_rd_b;
    logic [1:0]  state_b;

    assign mem_rd_a = use_model ? (mem_adr_a ^ 32'hA5A5_0000) : mem_drv_a;

    mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(2)) dut_a (
        .clk(clk), .reset(reset_a),
        .cpu_req(cpu_req_a), .cpu_we(cpu_we_a), .cpu_adr(cpu_adr_a), .cpu_wd(cpu_wd_a),
        .cpu_rd(cpu_rd_a), .cpu_done(cpu_done_a), .cpu_stall(cpu_stall_a),
        .dbg_req(dbg_req_a), .dbg_we(dbg_we_a), .dbg_adr(dbg_adr_a), .dbg_wd(dbg_wd_a),
        .dbg_rd(dbg_rd_a), .dbg_done(dbg_done_a),
        .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_adr(mem_adr_a), .mem_wd(mem_wd_a),
        .mem_rd(mem_rd_a), .owner(owner_a), .state(state_a)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(3)) dut_b (
        .clk(clk), .reset(reset_b),
        .cpu_req(cpu_req_b), .cpu_we(cpu_we_b), .cpu_adr(cpu_adr_b), .cpu_wd(cpu_wd_b),
        .cpu_rd(cpu_rd_b), .cpu_done(cpu_done_b), .cpu_stall(cpu_stall_b),
        .dbg_req(dbg_req_b), .dbg_we(dbg_we_b), .dbg_adr(dbg_adr_b), .dbg_wd(dbg_wd_b),
        .dbg_rd(dbg_rd_b), .dbg_done(dbg_done_b),
        .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_adr(mem_adr_b), .mem_wd(mem_wd_b),
        .mem_rd(mem_rd_b), .owner(owner_b), .state(state_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_a = 1'b1; reset_b = 1'b1;
        tick();
        n_checks++; if (state_a !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state_a); end
        n_checks++; if (mem_en_a !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en: got %b want 0", mem_en_a); end
        n_checks++; if (mem_we_a !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b want 0", mem_we_a); end
        n_checks++; if (mem_adr_a !== 32'h0) begin n_fail++; $display("FAIL reset_mem_adr: got %h want 0", mem_adr_a); end
        n_checks++; if (mem_wd_a !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wd: got %h want 0", mem_wd_a); end
        n_checks++; if (cpu_done_a !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_done: got %b want 0", cpu_done_a); end
        n_checks++; if (dbg_done_a !== 1'b0) begin n_fail++; $display("FAIL reset_dbg_done: got %b want 0", dbg_done_a); end
        n_checks++; if (cpu_rd_a !== 32'h0) begin n_fail++; $display("FAIL reset_cpu_rd: got %h want 0", cpu_rd_a); end
        n_checks++; if (dbg_rd_a !== 32'h0) begin n_fail++; $display("FAIL reset_dbg_rd: got %h want 0", dbg_rd_a); end
        n_checks++; if (owner_a !== 1'b0) begin n_fail++; $display("FAIL reset_owner: got %b want 0", owner_a); end
        n_checks++; if (cpu_stall_a !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_stall: got %b want 0", cpu_stall_a); end
        n_checks++; if (state_b !== 2'd0) begin n_fail++; $display("FAIL reset_state_b: got %0d want 0", state_b); end
        reset_a = 1'b0; reset_b = 1'b0;
    endtask

    task automatic test_cpu_write();
        cpu_req_a = 1'b1; cpu_we_a = 1'b1; cpu_adr_a = 32'h10; cpu_wd_a = 32'hDEAD_BEEF;
        #1;
        n_checks++; if (cpu_stall_a !== 1'b1) begin n_fail++; $display("FAIL wr_stall_c: got %b want 1", cpu_stall_a); end
        tick();
        n_checks++; if (mem_en_a !== 1'b1) begin n_fail++; $display("FAIL wr_mem_en: got %b want 1", mem_en_a); end
        n_checks++; if (mem_we_a !== 1'b1) begin n_fail++; $display("FAIL wr_mem_we: got %b want 1", mem_we_a); end
        n_checks++; if (mem_adr_a !== 32'h10) begin n_fail++; $display("FAIL wr_mem_adr: got %h want 10", mem_adr_a); end
        n_checks++; if (mem_wd_a !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_mem_wd: got %h want deadbeef", mem_wd_a); end
        n_checks++; if (cpu_stall_a !== 1'b1) begin n_fail++; $display("FAIL wr_stall_c1: got %b want 1", cpu_stall_a); end
        n_checks++; if (cpu_done_a !== 1'b0) begin n_fail++; $display("FAIL wr_done_early: got %b want 0", cpu_done_a); end
        tick();
        n_checks++; if (cpu_done_a !== 1'b1) begin n_fail++; $display("FAIL wr_cpu_done: got %b want 1", cpu_done_a); end
        n_checks++; if (cpu_stall_a !== 1'b0) begin n_fail++; $display("FAIL wr_stall_done: got %b want 0", cpu_stall_a); end
        n_checks++; if (mem_en_a !== 1'b0) begin n_fail++; $display("FAIL wr_mem_en_off: got %b want 0", mem_en_a); end
        n_checks++; if (mem_adr_a !== 32'h10) begin n_fail++; $display("FAIL wr_adr_hold: got %h want 10", mem_adr_a); end
        cpu_req_a = 1'b0; cpu_we_a = 1'b0;
        tick();
        n_checks++; if (state_a !== 2'd0) begin n_fail++; $display("FAIL wr_state_idle: got %0d want 0", state_a); end
        n_checks++; if (cpu_done_a !== 1'b0) begin n_fail++; $display("FAIL wr_done_pulse: got %b want 0", cpu_done_a); end
        n_checks++; if (cpu_rd_a !== 32'h0) begin n_fail++; $display("FAIL wr_rd_untouched: got %h want 0", cpu_rd_a); end
    endtask

    task automatic test_cpu_read();
        mem_drv_a = 32'hBAD0_BAD0;
        cpu_req_a = 1'b1; cpu_we_a = 1'b0; cpu_adr_a = 32'h20;
        tick();
        n_checks++; if (mem_en_a !== 1'b1) begin n_fail++; $display("FAIL rd_mem_en: got %b want 1", mem_en_a); end
        n_checks++; if (mem_we_a !== 1'b0) begin n_fail++; $display("FAIL rd_mem_we: got %b want 0", mem_we_a); end
        n_checks++; if (mem_adr_a !== 32'h20) begin n_fail++; $display("FAIL rd_mem_adr: got %h want 20", mem_adr_a); end
        tick();
        n_checks++; if (state_a !== 2'd2) begin n_fail++; $display("FAIL rd_state_wait: got %0d want 2", state_a); end
        tick();
        mem_drv_a = 32'h1234_5678;
        n_checks++; if (cpu_done_a !== 1'b0) begin n_fail++; $display("FAIL rd_done_early: got %b want 0", cpu_done_a); end
        tick();
        mem_drv_a = 32'hBAD0_BAD0;
        n_checks++; if (cpu_done_a !== 1'b1) begin n_fail++; $display("FAIL rd_cpu_done: got %b want 1", cpu_done_a); end
        n_checks++; if (cpu_rd_a !== 32'h1234_5678) begin n_fail++; $display("FAIL rd_cpu_rd: got %h want 12345678", cpu_rd_a); end
        n_checks++; if (dbg_rd_a !== 32'h0) begin n_fail++; $display("FAIL rd_dbg_rd: got %h want 0", dbg_rd_a); end
        cpu_req_a = 1'b0;
        tick();
        tick();
        n_checks++; if (cpu_rd_a !== 32'h1234_5678) begin n_fail++; $display("FAIL rd_cpu_rd_hold: got %h want 12345678", cpu_rd_a); end
        n_checks++; if (cpu_done_a !== 1'b0) begin n_fail++; $display("FAIL rd_done_pulse: got %b want 0", cpu_done_a); end
    endtask

    task automatic test_round_robin();
        int ndone  = 0;
        int ngrant = 0;
        reset_a = 1'b1;
        tick();
        reset_a = 1'b0;
        use_model = 1'b1;
        cpu_req_a = 1'b1; cpu_we_a = 1'b0; cpu_adr_a = 32'h100;
        dbg_req_a = 1'b1; dbg_we_a = 1'b0; dbg_adr_a = 32'h200;
        for (int cyc = 0; cyc < 60; cyc++) begin
            tick();
            if (mem_en_a) ngrant++;
            n_checks++;
            if (cpu_done_a && dbg_done_a) begin n_fail++; $display("FAIL rr_both_done: cycle %0d", cyc); end
            if (cpu_done_a || dbg_done_a) begin
                n_checks++;
                if (owner_a !== 1'(ndone % 2)) begin n_fail++; $display("FAIL rr_owner: grant %0d got %b want %0d", ndone, owner_a, ndone % 2); end
                n_checks++;
                if (dbg_done_a !== 1'(ndone % 2)) begin n_fail++; $display("FAIL rr_done_port: grant %0d dbg_done %b want %0d", ndone, dbg_done_a, ndone % 2); end
                n_checks++;
                if ((ndone % 2) == 0 && cpu_rd_a !== 32'hA5A5_0100) begin n_fail++; $display("FAIL rr_cpu_rd: got %h want a5a50100", cpu_rd_a); end
                else if ((ndone % 2) == 1 && dbg_rd_a !== 32'hA5A5_0200) begin n_fail++; $display("FAIL rr_dbg_rd: got %h want a5a50200", dbg_rd_a); end
                ndone++;
            end
            if (ndone == 4) begin
                cpu_req_a = 1'b0; dbg_req_a = 1'b0;
                break;
            end
        end
        n_checks++;
        if (ndone != 4) begin n_fail++; $display("FAIL rr_timeout: got %0d dones want 4", ndone); end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (mem_en_a) ngrant++;
            if (cpu_done_a || dbg_done_a) ndone++;
        end
        n_checks++; if (ngrant != 4) begin n_fail++; $display("FAIL rr_grants: got %0d want 4", ngrant); end
        n_checks++; if (ndone != 4) begin n_fail++; $display("FAIL rr_dones: got %0d want 4", ndone); end
        use_model = 1'b0;
    endtask

    task automatic b_read(input logic [31:0] adr, input logic [31:0] data);
        mem_rd_b = 32'hBAD0_BAD0;
        dbg_req_b = 1'b1; dbg_we_b = 1'b0; dbg_adr_b = adr;
        tick();
        tick();
        tick();
        tick();
        mem_rd_b = data;
        tick();
        mem_rd_b = 32'hBAD0_BAD0;
        n_checks++; if (dbg_done_b !== 1'b1) begin n_fail++; $display("FAIL b_rd_done adr %h: got %b want 1", adr, dbg_done_b); end
        n_checks++; if (dbg_rd_b !== data) begin n_fail++; $display("FAIL b_rd_data adr %h: got %h want %h", adr, dbg_rd_b, data); end
        dbg_req_b = 1'b0;
        tick();
        n_checks++; if (dbg_done_b !== 1'b0) begin n_fail++; $display("FAIL b_rd_pulse adr %h: got %b want 0", adr, dbg_done_b); end
    endtask

    task automatic test_reset_mid_read();
        b_read(32'h30, 32'h1111_2222);
        dbg_req_b = 1'b1; dbg_we_b = 1'b0; dbg_adr_b = 32'h34;
        tick();
        tick();
        tick();
        n_checks++; if (state_b !== 2'd2) begin n_fail++; $display("FAIL mr_in_wait: got %0d want 2", state_b); end
        reset_b = 1'b1; dbg_req_b = 1'b0; mem_rd_b = 32'hFFFF_0000;
        tick();
        reset_b = 1'b0;
        n_checks++; if (state_b !== 2'd0) begin n_fail++; $display("FAIL mr_state: got %0d want 0", state_b); end
        n_checks++; if (dbg_done_b !== 1'b0) begin n_fail++; $display("FAIL mr_dbg_done: got %b want 0", dbg_done_b); end
        n_checks++; if (dbg_rd_b !== 32'h0) begin n_fail++; $display("FAIL mr_dbg_rd: got %h want 0", dbg_rd_b); end
        n_checks++; if (mem_en_b !== 1'b0) begin n_fail++; $display("FAIL mr_mem_en: got %b want 0", mem_en_b); end
        tick();
        tick();
        n_checks++; if (dbg_done_b !== 1'b0) begin n_fail++; $display("FAIL mr_late_done: got %b want 0", dbg_done_b); end
        n_checks++; if (dbg_rd_b !== 32'h0) begin n_fail++; $display("FAIL mr_late_rd: got %h want 0", dbg_rd_b); end
        b_read(32'h40, 32'hCAFE_0001);
    endtask

    task automatic test_back_to_back();
        dbg_req_a = 1'b1; dbg_we_a = 1'b1; dbg_adr_a = 32'h50; dbg_wd_a = 32'h5555_AAAA;
        tick();
        cpu_req_a = 1'b1; cpu_we_a = 1'b1; cpu_adr_a = 32'h60; cpu_wd_a = 32'h6666_6666;
        #1;
        n_checks++; if (owner_a !== 1'b1) begin n_fail++; $display("FAIL bb_owner_dbg: got %b want 1", owner_a); end
        n_checks++; if (mem_adr_a !== 32'h50) begin n_fail++; $display("FAIL bb_dbg_adr: got %h want 50", mem_adr_a); end
        n_checks++; if (cpu_stall_a !== 1'b1) begin n_fail++; $display("FAIL bb_stall_issue: got %b want 1", cpu_stall_a); end
        tick();
        n_checks++; if (dbg_done_a !== 1'b1) begin n_fail++; $display("FAIL bb_dbg_done: got %b want 1", dbg_done_a); end
        n_checks++; if (cpu_stall_a !== 1'b1) begin n_fail++; $display("FAIL bb_stall_resp: got %b want 1", cpu_stall_a); end
        dbg_req_a = 1'b0;
        tick();
        n_checks++; if (state_a !== 2'd0) begin n_fail++; $display("FAIL bb_idle: got %0d want 0", state_a); end
        n_checks++; if (cpu_stall_a !== 1'b1) begin n_fail++; $display("FAIL bb_stall_idle: got %b want 1", cpu_stall_a); end
        tick();
        n_checks++; if (mem_en_a !== 1'b1) begin n_fail++; $display("FAIL bb_cpu_issue: got %b want 1", mem_en_a); end
        n_checks++; if (owner_a !== 1'b0) begin n_fail++; $display("FAIL bb_owner_cpu: got %b want 0", owner_a); end
        n_checks++; if (mem_adr_a !== 32'h60) begin n_fail++; $display("FAIL bb_cpu_adr: got %h want 60", mem_adr_a); end
        n_checks++; if (mem_wd_a !== 32'h6666_6666) begin n_fail++; $display("FAIL bb_cpu_wd: got %h want 66666666", mem_wd_a); end
        tick();
        n_checks++; if (cpu_done_a !== 1'b1) begin n_fail++; $display("FAIL bb_cpu_done: got %b want 1", cpu_done_a); end
        n_checks++; if (cpu_stall_a !== 1'b0) begin n_fail++; $display("FAIL bb_stall_end: got %b want 0", cpu_stall_a); end
        cpu_req_a = 1'b0;
        tick();
        n_checks++; if (state_a !== 2'd0) begin n_fail++; $display("FAIL bb_final_idle: got %0d want 0", state_a); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_a = 1'b1; reset_b = 1'b1; use_model = 1'b0;
        cpu_req_a = 1'b0; cpu_we_a = 1'b0; cpu_adr_a = '0; cpu_wd_a = '0;
        dbg_req_a = 1'b0; dbg_we_a = 1'b0; dbg_adr_a = '0; dbg_wd_a = '0;
        mem_drv_a = '0;
        cpu_req_b = 1'b0; cpu_we_b = 1'b0; cpu_adr_b = '0; cpu_wd_b = '0;
        dbg_req_b = 1'b0; dbg_we_b = 1'b0; dbg_adr_b = '0; dbg_wd_b = '0;
        mem_rd_b = '0;
        test_reset();
        test_cpu_write();
        test_cpu_read();
        test_round_robin();
        test_reset_mid_read();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single unified instruction/data memory between the multi-cycle CPU and a debug/loader port. The block accepts one transaction at a time from either requester and sequences it through the memory with a fixed read latency. It returns read data and a one-cycle done pulse to the requester that owns the transaction. It drives a stall to the CPU control FSM so the CPU holds its state while it waits.

Parameters:
AW, 32, address width
DW, 32, data width
RD_LAT, 1, cycles from the issue cycle to valid mem_rd (legal range 1..15)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cpu_req  in  1  CPU transaction request; held until cpu_done
cpu_we  in  1  CPU write enable (1 = write)
cpu_adr  in  AW  CPU address
cpu_wd  in  DW  CPU write data
cpu_rd  out  DW  last CPU read data, registered
cpu_done  out  1  one-cycle pulse when the CPU transaction completes
cpu_stall  out  1  cpu_req & ~cpu_done, combinational
dbg_req  in  1  debug request; held until dbg_done
dbg_we  in  1  debug write enable
dbg_adr  in  AW  debug address
dbg_wd  in  DW  debug write data
dbg_rd  out  DW  last debug read data, registered
dbg_done  out  1  one-cycle pulse when the debug transaction completes
mem_en  out  1  memory access strobe, high only in ISSUE
mem_we  out  1  memory write, high only in ISSUE for writes
mem_adr  out  AW  latched address
mem_wd  out  DW  latched write data
mem_rd  in  DW  memory read data
owner  out  1  0 = CPU, 1 = debug; owner of the current or last transaction
state  out  2  IDLE=0, ISSUE=1, WAIT=2, RESP=3, for visibility

Behaviour:
- Only one clock domain. All state updates on posedge clk. Reset is synchronous.
- Reset values: state=IDLE; every output register is 0: cpu_rd, dbg_rd, done pulses, mem_*, owner. last_grant=debug, so the CPU wins the first tie. Wait counter=0.
- IDLE:
  - Requests are sampled only in IDLE.
  - No request: stay in IDLE.
  - Exactly one request: that requester wins.
  - Both request: the requester not equal to last_grant wins (round-robin).
  - Winner's we/adr/wd are latched into mem_we_q/mem_adr/mem_wd. owner and last_grant are set to the winner. Next state is ISSUE.
- ISSUE (1 cycle):
  - mem_en=1; mem_we=latched we.
  - Write: next state is RESP.
  - Read: wait counter loads RD_LAT; next state is WAIT.
- WAIT:
  - Counter decrements each cycle.
  - In the cycle the counter equals 1, mem_rd is captured into the owner's rd register. The other port's rd register is untouched. Next state is RESP.
  - Read data is therefore sampled exactly RD_LAT cycles after the ISSUE cycle.
- RESP (1 cycle): owner's done=1. Next state is IDLE.
- Latency, with the request first seen in IDLE at cycle c:
  - Write: mem_en at c+1, done at c+2.
  - Read: mem_en at c+1, capture at c+1+RD_LAT, done at c+2+RD_LAT.
  - Next arbitration at c+3 (write) or c+3+RD_LAT (read).
- Outside ISSUE: mem_en=0 and mem_we=0; mem_adr and mem_wd hold their latched values.
- Requester obligations: keep req, we, adr and wd stable from assertion until done.
  - A req still high in the cycle after done is treated as a new transaction.
  - Dropping req mid-transaction does not abort it; the transaction completes and done still pulses.
- Fairness: when both request continuously, grants strictly alternate (CPU, debug, CPU, ...). Neither requester starves.
- cpu_rd and dbg_rd hold their value until that port's next read completes. Writes never modify them.
- Reset mid-transaction:
  - The next state is IDLE with all reset values, and no done pulse is generated.
  - An in-flight read is abandoned; a late mem_rd is ignored.
  - mem_en and mem_we are low in the cycle after reset is sampled.
- Reset takes priority over all other events in the same cycle.

Test Plan:
- Reset -> after one clk with reset=1, the following are all 0: state, mem_en, mem_we, mem_adr, cpu_done, dbg_done, cpu_rd, dbg_rd, owner, cpu_stall (no req).
- RD_LAT=2, CPU write adr 0x10 wd 0xDEADBEEF at cycle c -> expect:
  - cycle c+1: mem_en=1, mem_we=1, mem_adr=0x10, mem_wd=0xDEADBEEF
  - cycle c+2: cpu_done=1
  - cycle c+3: state=0
  - cpu_stall=1 during c..c+1
- RD_LAT=2, CPU read adr 0x20, memory drives 0x12345678 at c+3 -> expect:
  - mem_en=1 and mem_we=0 at c+1
  - cpu_done=1 at c+4
  - cpu_rd=0x12345678 from c+4 and held afterwards
  - dbg_rd unchanged
- Both ports request reads from reset and hold req for 4 transactions -> owner sequence 0,1,0,1. Each done pulses exactly once per grant, and dbg_done never coincides with cpu_done.
- RD_LAT=3, debug read in WAIT, reset pulsed for 1 cycle -> expect:
  - next cycle: state=0, no dbg_done, dbg_rd=0
  - a following debug read of adr 0x40 (data 0xCAFE0001) completes with dbg_done and dbg_rd=0xCAFE0001
- Debug write in ISSUE when cpu_req rises -> CPU waits; cpu_stall=1 until cpu_done. The CPU transaction issues the cycle after dbg RESP+IDLE arbitration, with owner=0.
